// File: rtl/apb_initiator.sv
// Single-outstanding APB4 initiator: valid/ready command in, APB SETUP/ACCESS out, one response per command.
// Optional ACCESS-phase timeout abort is compiled in when APB_INIT_TIMEOUT_EN is defined.
module apb_initiator #(
  parameter int ADDR_W  = 12,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [31:0]       cmd_wdata,
  input  logic [3:0]        cmd_strb,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              busy,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [31:0]       pwdata,
  output logic [3:0]        pstrb,
  input  logic [31:0]       prdata,
  input  logic              pready,
  input  logic              pslverr
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic                cmd_ready_q;
  logic                rsp_valid_q;
  logic [31:0]         rsp_rdata_q;
  logic                rsp_err_q;
  logic                rsp_timeout_q;
  logic                psel_q;
  logic                penable_q;
  logic                pwrite_q;
  logic [ADDR_W-1:0]   paddr_q;
  logic [31:0]         pwdata_q;
  logic [3:0]          pstrb_q;
  logic                timeout_hit;

  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("apb_initiator: TIMEOUT must be at least 2");
  end

`ifdef APB_INIT_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  logic [WAIT_W-1:0] wait_q;

  // The k-th ACCESS cycle sees wait_q == k-1, so the TIMEOUT-th cycle is the last one allowed.
  assign timeout_hit = (wait_q == WAIT_W'(TIMEOUT - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) state_d = SETUP;
        else                          state_d = IDLE;
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        if (pready || timeout_hit) state_d = RESP;
        else                       state_d = ACCESS;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
        else           state_d = RESP;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cmd_ready_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= 32'h0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= 32'h0;
      pstrb_q       <= 4'h0;
`ifdef APB_INIT_TIMEOUT_EN
      wait_q        <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= (state_d == IDLE);
      case (state_q)
        IDLE: begin
          if (cmd_valid && cmd_ready_q) begin
            // Reads never expose write data or strobes on the bus.
            psel_q    <= 1'b1;
            penable_q <= 1'b0;
            pwrite_q  <= cmd_write;
            paddr_q   <= cmd_addr;
            pwdata_q  <= cmd_write ? cmd_wdata : 32'h0;
            pstrb_q   <= cmd_write ? cmd_strb : 4'h0;
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
`ifdef APB_INIT_TIMEOUT_EN
          wait_q    <= '0;
`endif
        end
        ACCESS: begin
          if (pready || timeout_hit) begin
            rsp_valid_q   <= 1'b1;
            // pready wins over a coincident timeout.
            rsp_rdata_q   <= (pready && !pwrite_q) ? prdata : 32'h0;
            rsp_err_q     <= pready ? pslverr : 1'b1;
            rsp_timeout_q <= !pready;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= 32'h0;
            pstrb_q       <= 4'h0;
          end else begin
`ifdef APB_INIT_TIMEOUT_EN
            if (wait_q != {WAIT_W{1'b1}}) wait_q <= wait_q + WAIT_W'(1);
`endif
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= 32'h0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
          end
        end
        default: begin
          psel_q    <= 1'b0;
          penable_q <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
`ifdef APB_INIT_TIMEOUT_EN
  assign rsp_timeout = rsp_timeout_q;
`else
  assign rsp_timeout = 1'b0;
`endif
  assign busy    = (state_q != IDLE);
  assign psel    = psel_q;
  assign penable = penable_q;
  assign pwrite  = pwrite_q;
  assign paddr   = paddr_q;
  assign pwdata  = pwdata_q;
  assign pstrb   = pstrb_q;

endmodule

// File: tb/tb_apb_initiator.sv
// Directed, table-driven bench for apb_initiator: per-cycle APB checks plus reset and stall/timeout sequences.
module tb_apb_initiator;

  localparam int ADDR_W  = 12;
  localparam int TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic              cmd_write = 1'b0;
  logic [ADDR_W-1:0] cmd_addr = '0;
  logic [31:0]       cmd_wdata = 32'h0;
  logic [3:0]        cmd_strb = 4'h0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;
  logic              busy;
  logic              psel, penable, pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [31:0]       pwdata;
  logic [3:0]        pstrb;
  logic [31:0]       prdata = 32'h0;
  logic              pready = 1'b0;
  logic              pslverr = 1'b0;

  int tests = 0;
  int fails = 0;

  apb_initiator #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout), .busy(busy),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata), .pready(pready),
    .pslverr(pslverr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          waits;
    logic [31:0] prdata;
    logic        slverr;
    int          hold;
    logic [31:0] exp_pwdata;
    logic [3:0]  exp_pstrb;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Handshake a command, then check the SETUP cycle; leaves the DUT entering ACCESS at the next edge.
  task automatic send_cmd(input logic wr, input logic [11:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, input logic [31:0] exp_pwdata, input logic [3:0] exp_pstrb);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata; cmd_strb = strb;
    check("idle_cmd_ready", cmd_ready, 1);
    check("idle_psel", psel, 0);
    tick();
    cmd_valid = 1'b0; cmd_write = ~wr; cmd_addr = ~addr; cmd_wdata = 32'h5A5A_5A5A; cmd_strb = ~strb;
    check("setup_psel", psel, 1);
    check("setup_penable", penable, 0);
    check("setup_paddr", paddr, addr);
    check("setup_pwrite", pwrite, wr);
    check("setup_pwdata", pwdata, exp_pwdata);
    check("setup_pstrb", pstrb, exp_pstrb);
    check("setup_cmd_ready", cmd_ready, 0);
    check("setup_busy", busy, 1);
    @(posedge clk);
  endtask

  // Check the RESP cycle, hold rsp_ready low for 'hold' cycles, then retire the response.
  task automatic check_resp(input logic [31:0] exp_rdata, input logic exp_err, input logic exp_to, input int hold);
    @(negedge clk);
    pready = 1'b0; pslverr = 1'b0; prdata = 32'hBAD0_BAD0;
    for (int h = 0; h <= hold; h++) begin
      check("resp_valid", rsp_valid, 1);
      check("resp_rdata", rsp_rdata, exp_rdata);
      check("resp_err", rsp_err, exp_err);
      check("resp_timeout", rsp_timeout, exp_to);
      check("resp_psel", {psel, penable, pwrite}, 0);
      check("resp_apb_zero", {paddr, pwdata, pstrb}, 0);
      check("resp_cmd_ready", cmd_ready, 0);
      if (h < hold) tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("retire_rsp_valid", rsp_valid, 0);
    check("retire_cmd_ready", cmd_ready, 1);
    check("retire_busy", busy, 0);
  endtask

  task automatic run_vec(input vec_t v);
    send_cmd(v.wr, v.addr, v.wdata, v.strb, v.exp_pwdata, v.exp_pstrb);
    for (int i = 0; i <= v.waits; i++) begin
      @(negedge clk);
      check("access_psel", {psel, penable}, 2'b11);
      check("access_paddr", paddr, v.addr);
      check("access_pwdata", pwdata, v.exp_pwdata);
      check("access_pstrb", pstrb, v.exp_pstrb);
      check("access_rsp_valid", rsp_valid, 0);
      pready  = (i == v.waits);
      prdata  = (i == v.waits) ? v.prdata : (32'h1000_0000 + 32'(i));
      pslverr = (i == v.waits) ? v.slverr : 1'b1;
      @(posedge clk);
    end
    check_resp(v.exp_rdata, v.exp_err, 1'b0, v.hold);
  endtask

  // Read that sees pready low for n-1 ACCESS cycles; on the n-th cycle pready = last_ready.
  task automatic stall_read(input logic [11:0] addr, input int n, input logic last_ready,
                            input logic [31:0] last_prdata);
    send_cmd(1'b0, addr, 32'hFFFF_FFFF, 4'hF, 32'h0, 4'h0);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("stall_psel", {psel, penable}, 2'b11);
      check("stall_paddr", paddr, addr);
      check("stall_rsp_valid", rsp_valid, 0);
      pready  = (i == n - 1) && last_ready;
      prdata  = (i == n - 1) ? last_prdata : 32'(i);
      pslverr = 1'b0;
      @(posedge clk);
    end
  endtask

  initial begin
    vecs[0] = '{wr:1'b1, addr:12'h000, wdata:32'h0000_0101, strb:4'h3, waits:0, prdata:32'hAAAA_5555,
                slverr:1'b0, hold:0, exp_pwdata:32'h0000_0101, exp_pstrb:4'h3, exp_rdata:32'h0, exp_err:1'b0};
    vecs[1] = '{wr:1'b0, addr:12'h00C, wdata:32'hDEAD_BEEF, strb:4'hF, waits:0, prdata:32'hFFFF_FFFF,
                slverr:1'b0, hold:0, exp_pwdata:32'h0, exp_pstrb:4'h0, exp_rdata:32'hFFFF_FFFF, exp_err:1'b0};
    vecs[2] = '{wr:1'b0, addr:12'h018, wdata:32'h1234_5678, strb:4'h1, waits:3, prdata:32'h0000_0001,
                slverr:1'b0, hold:1, exp_pwdata:32'h0, exp_pstrb:4'h0, exp_rdata:32'h0000_0001, exp_err:1'b0};
    vecs[3] = '{wr:1'b1, addr:12'h000, wdata:32'h0000_0900, strb:4'h2, waits:0, prdata:32'h7777_7777,
                slverr:1'b1, hold:5, exp_pwdata:32'h0000_0900, exp_pstrb:4'h2, exp_rdata:32'h0, exp_err:1'b1};
    vecs[4] = '{wr:1'b0, addr:12'hFFC, wdata:32'h0, strb:4'h0, waits:2, prdata:32'h1234_5678,
                slverr:1'b1, hold:0, exp_pwdata:32'h0, exp_pstrb:4'h0, exp_rdata:32'h1234_5678, exp_err:1'b1};
    vecs[5] = '{wr:1'b1, addr:12'h7F0, wdata:32'hCAFE_F00D, strb:4'hA, waits:1, prdata:32'h0,
                slverr:1'b0, hold:2, exp_pwdata:32'hCAFE_F00D, exp_pstrb:4'hA, exp_rdata:32'h0, exp_err:1'b0};

    // Reset state
    cmd_valid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_rsp_valid", {rsp_valid, rsp_err, rsp_timeout}, 0);
    check("rst_apb", {psel, penable, pwrite, paddr, pwdata, pstrb}, 0);
    check("rst_busy", busy, 0);
    check("rst_rdata", rsp_rdata, 0);
    cmd_valid = 1'b0;
    rst = 1'b0;
    tick();
    check("post_rst_cmd_ready", cmd_ready, 1);
    check("post_rst_busy", busy, 0);

    // Back-to-back table vectors
    for (int k = 0; k < 6; k++) run_vec(vecs[k]);

    // Reset during ACCESS discards the transfer
    send_cmd(1'b0, 12'h010, 32'h0, 4'h0, 32'h0, 4'h0);
    @(negedge clk);
    check("pre_rst_access", {psel, penable}, 2'b11);
    rst = 1'b1; pready = 1'b1; prdata = 32'h9999_9999;
    tick();
    rst = 1'b0; pready = 1'b0;
    check("mid_rst_psel", {psel, penable}, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_rsp_valid", rsp_valid, 0);
    check("mid_rst_cmd_ready", cmd_ready, 0);
    tick();
    check("after_rst_rsp_valid", rsp_valid, 0);
    check("after_rst_cmd_ready", cmd_ready, 1);
    send_cmd(1'b0, 12'h004, 32'h0, 4'hF, 32'h0, 4'h0);
    @(negedge clk);
    pready = 1'b1; prdata = 32'h0000_00A5; pslverr = 1'b0;
    @(posedge clk);
    check_resp(32'h0000_00A5, 1'b0, 1'b0, 0);

`ifdef APB_INIT_TIMEOUT_EN
    stall_read(12'h020, TIMEOUT, 1'b0, 32'h0000_0055);
    check_resp(32'h0, 1'b1, 1'b1, 1);
    stall_read(12'h024, TIMEOUT, 1'b1, 32'h0000_0055);
    check_resp(32'h0000_0055, 1'b0, 1'b0, 0);
`else
    stall_read(12'h020, 40, 1'b1, 32'h0000_0055);
    check_resp(32'h0000_0055, 1'b0, 1'b0, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/apb_initiator.md
# apb_initiator

Single-outstanding APB4 initiator that turns a simple valid/ready command port into APB SETUP/ACCESS transfers toward peripheral register sets such as the timer register block. It drives PSEL/PENABLE/PADDR/PWRITE/PWDATA/PSTRB, honours PREADY wait states, captures PRDATA/PSLVERR, and returns one response per command. It sits between a test sequencer or CPU-side bridge and the APB fabric.

## Interface
- ADDR_W, 12, APB address width
- TIMEOUT, 16, max ACCESS cycles without PREADY before abort; minimum 2
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  command accepted when cmd_valid & cmd_ready
- cmd_write  input  1  1 = write, 0 = read
- cmd_addr  input  ADDR_W  target address
- cmd_wdata  input  32  write data
- cmd_strb  input  4  byte strobes, writes only
- rsp_valid  output  1  response present
- rsp_ready  input  1  response consumed when rsp_valid & rsp_ready
- rsp_rdata  output  32  read data; 0 for writes and aborted transfers
- rsp_err  output  1  PSLVERR or timeout
- rsp_timeout  output  1  transfer aborted by timeout
- busy  output  1  state != IDLE
- psel, penable, pwrite  output  1 each  APB control
- paddr  output  ADDR_W  APB address
- pwdata  output  32  APB write data
- pstrb  output  4  APB strobes
- prdata  input  32  APB read data
- pready  input  1  APB ready
- pslverr  input  1  APB error

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP. All outputs registered or decoded from state/held registers.
- IDLE: cmd_ready=1. On handshake latch cmd fields -> SETUP.
- SETUP: psel=1, penable=0 -> ACCESS unconditionally.
- ACCESS: psel=1, penable=1. pready=1 -> latch rsp_rdata = pwrite ? 0 : prdata, rsp_err = pslverr, rsp_timeout=0 -> RESP. pready=0 -> stay, wait counter +1.
- RESP: rsp_valid=1, psel=penable=0; fields held stable until rsp_ready=1 -> IDLE.
- paddr, pwrite, pwdata, pstrb constant from SETUP through final ACCESS cycle. Reads: pwdata=0, pstrb=4'h0 regardless of cmd inputs. Outside SETUP/ACCESS all APB outputs 0.
- pslverr and prdata sampled only in ACCESS with pready=1; ignored otherwise.
- cmd_ready=0 in SETUP/ACCESS/RESP: exactly one outstanding transfer.

## Timing
- Reset values: cmd_ready=0 during reset, 1 in first cycle after reset release; all other outputs 0; state IDLE; wait counter 0.
- Zero-wait transfer: handshake edge T0 -> SETUP T1 -> ACCESS T2 (pready=1) -> rsp_valid T3. N wait states add N cycles.
- Back-to-back: RESP with rsp_ready -> IDLE next cycle; next command accepted there; minimum 4 cycles per transfer.
- Wait counter: cleared in SETUP; saturates, never wraps.
- Timeout (macro defined): if pready still 0 in TIMEOUT-th ACCESS cycle -> RESP with rsp_err=1, rsp_timeout=1, rsp_rdata=0; psel/penable drop next cycle. pready=1 in that same cycle wins: normal completion.
- rst asserted in any state -> IDLE at next edge, APB outputs 0, pending response discarded, no rsp_valid produced.
- cmd_* changes after handshake have no effect on in-flight transfer.

## Configuration
- APB_INIT_TIMEOUT_EN defined: wait counter and abort path present, TIMEOUT honoured.
- Not defined: no counter; ACCESS waits indefinitely for pready; rsp_timeout tied 0; TIMEOUT parameter unused.

## Test plan
- Write 0x000, wdata 0x0000_0101, strb 4'h3, pready=1 in ACCESS -> psel T1-T2, penable T2 only, paddr 0x000, pstrb 4'h3; rsp_valid T3, rsp_err=0, rsp_rdata=0.
- Read 0x00C, cmd_wdata 0xDEAD_BEEF, strb 4'hF, prdata 0xFFFF_FFFF -> pwdata 0, pstrb 0; rsp_rdata 0xFFFF_FFFF.
- Read 0x018 with 3 wait states, prdata changing each cycle, final 0x0000_0001 -> ACCESS lasts 4 cycles, paddr stable, rsp_rdata 0x0000_0001 at T6.
- Write 0x000 wdata 0x0000_0900 strb 4'h2, pslverr=1 with pready -> rsp_err=1, rsp_timeout=0; rsp_ready held low 5 cycles -> response stable, cmd_ready=0 throughout.
- Macro defined, TIMEOUT=16, pready stuck 0 -> 16 ACCESS cycles, then rsp_err=1, rsp_timeout=1, rsp_rdata=0; pready=1 on 16th cycle -> normal completion instead.
- rst pulsed during ACCESS -> next cycle psel=penable=0, busy=0, no rsp_valid; new read to 0x004 afterwards completes normally.
